// File: rtl/sgx_pkg.sv
// Shared types and constants for the enclave loader: FSM states, error codes, page geometry.
package sgx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CREATE,
    ST_FETCH,
    ST_ADD,
    ST_INIT,
    ST_ENTER,
    ST_WAIT_ACT,
    ST_RUN,
    ST_EXIT,
    ST_ERROR
  } sgx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_FAULT   = 2'd3
  } sgx_err_e;

  localparam int PAGE_SHIFT    = 8;
  localparam int SGX_MAX_PAGES = 256;

  // Page k of an enclave; the add wraps at 64 bits.
  function automatic logic [63:0] page_addr(input logic [63:0] base, input logic [8:0] k);
    return base + ({55'b0, k} << PAGE_SHIFT);
  endfunction

endpackage

// File: rtl/sgx_timeout_ctr.sv
// Clearable saturating cycle counter; expired is high during the RD_TIMEOUT-th counted cycle.
module sgx_timeout_ctr #(
  parameter int RD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != CW'(RD_TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= CW'(RD_TIMEOUT - 1));

endmodule

// File: rtl/sgx_enclave_loader.sv
// Sequences ECREATE / per-page fetch+EADD / EINIT / EENTER, then supervises the running enclave.
// Command pulses, fetch request and addresses are registered; status flags decode the state register.
module sgx_enclave_loader
  import sgx_pkg::*;
#(
  parameter int MAX_PAGES  = SGX_MAX_PAGES,
  parameter int RD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_base_i,
  input  logic [8:0]  req_pages_i,
  input  logic        exit_req_i,
  output logic        rd_req_o,
  output logic [63:0] rd_addr_o,
  input  logic        rd_valid_i,
  input  logic [63:0] rd_data_i,
  output logic        ecreate_o,
  output logic        eadd_o,
  output logic        einit_o,
  output logic        eenter_o,
  output logic        eexit_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  input  logic        active_i,
  input  logic        sgx_fault_i,
  output logic        busy_o,
  output logic        running_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [9:0]  MAX_P     = 10'(MAX_PAGES);
  localparam logic [63:0] PAGE_MASK = ~((64'd1 << PAGE_SHIFT) - 64'd1);

  sgx_state_e  state;
  sgx_err_e    err_code;
  logic [63:0] base;
  logic [8:0]  pages;
  logic [8:0]  k;
  logic        tmo_clr;
  logic        tmo;
  logic        bad_len;
  logic [63:0] req_base_al;

  // The counter only runs in the three waiting states, so each entry starts it from zero.
  assign tmo_clr = !(state inside {ST_FETCH, ST_WAIT_ACT, ST_EXIT});

  sgx_timeout_ctr #(.RD_TIMEOUT(RD_TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .expired (tmo)
  );

  assign bad_len     = (req_pages_i == 9'd0) || ({1'b0, req_pages_i} > MAX_P);
  assign req_base_al = req_base_i & PAGE_MASK;

  assign req_ready_o = (state == ST_IDLE) || (state == ST_ERROR);
  assign busy_o      = !req_ready_o;
  assign running_o   = (state == ST_RUN);
  assign err_o       = (state == ST_ERROR);
  assign err_code_o  = err_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      err_code  <= ERR_NONE;
      base      <= '0;
      pages     <= '0;
      k         <= '0;
      rd_req_o  <= 1'b0;
      rd_addr_o <= '0;
      ecreate_o <= 1'b0;
      eadd_o    <= 1'b0;
      einit_o   <= 1'b0;
      eenter_o  <= 1'b0;
      eexit_o   <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
      done_o    <= 1'b0;
    end else begin
      ecreate_o <= 1'b0;
      eadd_o    <= 1'b0;
      einit_o   <= 1'b0;
      eenter_o  <= 1'b0;
      eexit_o   <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
      done_o    <= 1'b0;

      case (state)
        ST_IDLE, ST_ERROR: begin
          if (req_valid_i) begin
            base     <= req_base_al;
            pages    <= req_pages_i;
            k        <= '0;
            err_code <= ERR_NONE;
            if (bad_len) begin
              state    <= ST_ERROR;
              err_code <= ERR_LEN;
            end else begin
              state     <= ST_CREATE;
              ecreate_o <= 1'b1;
              addr_o    <= req_base_al;
            end
          end
        end
        ST_CREATE: begin
          state     <= ST_FETCH;
          k         <= '0;
          rd_req_o  <= 1'b1;
          rd_addr_o <= base;
        end
        ST_FETCH: begin
          if (rd_valid_i) begin
            state     <= ST_ADD;
            rd_req_o  <= 1'b0;
            rd_addr_o <= '0;
            eadd_o    <= 1'b1;
            addr_o    <= rd_addr_o;
            wdata_o   <= rd_data_i;
          end else if (tmo) begin
            state     <= ST_ERROR;
            err_code  <= ERR_TIMEOUT;
            rd_req_o  <= 1'b0;
            rd_addr_o <= '0;
          end
        end
        ST_ADD: begin
          if (k == pages - 9'd1) begin
            state   <= ST_INIT;
            einit_o <= 1'b1;
          end else begin
            state     <= ST_FETCH;
            k         <= k + 9'd1;
            rd_req_o  <= 1'b1;
            rd_addr_o <= page_addr(base, k + 9'd1);
          end
        end
        ST_INIT: begin
          state    <= ST_ENTER;
          eenter_o <= 1'b1;
        end
        ST_ENTER: state <= ST_WAIT_ACT;
        ST_WAIT_ACT: begin
          if (active_i) begin
            state <= ST_RUN;
          end else if (tmo) begin
            state    <= ST_ERROR;
            err_code <= ERR_TIMEOUT;
          end
        end
        ST_RUN: begin
          // A fault wins over a simultaneous software exit.
          if (sgx_fault_i) begin
            state    <= ST_ERROR;
            err_code <= ERR_FAULT;
            eexit_o  <= 1'b1;
          end else if (exit_req_i) begin
            state   <= ST_EXIT;
            eexit_o <= 1'b1;
          end
        end
        ST_EXIT: begin
          if (!active_i) begin
            state  <= ST_IDLE;
            done_o <= 1'b1;
          end else if (tmo) begin
            state    <= ST_ERROR;
            err_code <= ERR_TIMEOUT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgx_enclave_loader.sv
// Directed bench for sgx_enclave_loader: table of load requests plus hand-written corner sequences.
module tb_sgx_enclave_loader;

  localparam logic [63:0] MAGIC = 64'hA5A5_0F0F_3C3C_9696;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_base_i = '0;
  logic [8:0]  req_pages_i = '0;
  logic        exit_req_i = 1'b0;
  logic        rd_req_o;
  logic [63:0] rd_addr_o;
  logic        rd_valid_i = 1'b0;
  logic [63:0] rd_data_i;
  logic        ecreate_o, eadd_o, einit_o, eenter_o, eexit_o;
  logic [63:0] addr_o, wdata_o;
  logic        active_i = 1'b1;
  logic        sgx_fault_i = 1'b0;
  logic        busy_o, running_o, done_o, err_o;
  logic [1:0]  err_code_o;

  sgx_enclave_loader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_base_i(req_base_i), .req_pages_i(req_pages_i), .exit_req_i(exit_req_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .ecreate_o(ecreate_o), .eadd_o(eadd_o), .einit_o(einit_o), .eenter_o(eenter_o),
    .eexit_o(eexit_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .active_i(active_i), .sgx_fault_i(sgx_fault_i),
    .busy_o(busy_o), .running_o(running_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );

  // Fetch memory model: each page's contents derive from its address.
  assign rd_data_i = rd_addr_o ^ MAGIC;

  always #5 clk = ~clk;

  logic [203:0] non_ready_outs;
  assign non_ready_outs = {rd_req_o, rd_addr_o, ecreate_o, eadd_o, einit_o, eenter_o, eexit_o,
                           addr_o, wdata_o, busy_o, running_o, done_o, err_o, err_code_o};

  int checks = 0;
  int errors = 0;
  int n_create, n_add, n_init, n_enter, n_exit, n_done, n_rd;

  typedef struct {
    logic [63:0] base;
    logic [8:0]  pages;
    logic [63:0] exp_create;
    int          exp_adds;
    logic [1:0]  exp_code;
    bit          exp_run;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and follow it until RUN or ERROR, checking every EADD on the way.
  task automatic load_seq(input logic [63:0] base, input logic [8:0] pages,
                          input logic [63:0] exp_create);
    logic [63:0] base_al;
    logic [63:0] exp_addr;
    int          k_exp;
    int          pulses;
    bit          fin;
    base_al = base & 64'hFFFF_FFFF_FFFF_FF00;
    n_create = 0; n_add = 0; n_init = 0; n_enter = 0;
    k_exp = 0;
    fin = 1'b0;
    req_base_i  = base;
    req_pages_i = pages;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 1200 && !fin; c++) begin
      pulses = $countones({ecreate_o, eadd_o, einit_o, eenter_o, eexit_o});
      if (pulses > 1) chk("cmd_onehot", 64'(pulses), 64'd1);
      if (ecreate_o) begin
        n_create++;
        chk("ecreate_addr", addr_o, exp_create);
      end
      if (eadd_o) begin
        exp_addr = base_al + 64'(k_exp) * 64'd256;
        chk("eadd_addr", addr_o, exp_addr);
        chk("eadd_wdata", wdata_o, exp_addr ^ MAGIC);
        k_exp++;
        n_add++;
      end
      if (einit_o) n_init++;
      if (eenter_o) n_enter++;
      if (running_o || err_o) fin = 1'b1;
      else tick();
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL load_bound: got no RUN/ERROR expected one within 1200 cycles");
    end
  endtask

  // Software exit from RUN; active_i falls 'delay' cycles after the request.
  task automatic exit_seq(input int delay);
    n_exit = 0; n_done = 0;
    for (int c = 0; c < 12; c++) begin
      exit_req_i = (c == 0);
      if (c == delay) active_i = 1'b0;
      tick();
      if (eexit_o) n_exit++;
      if (done_o) n_done++;
    end
    active_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{64'h0000_0000_1234_5678, 9'd2,   64'h0000_0000_1234_5600, 2,   2'd0, 1'b1};
    vecs[1] = '{64'h0000_0000_1234_5678, 9'd0,   64'h0,                   0,   2'd1, 1'b0};
    vecs[2] = '{64'h0000_0000_1234_5678, 9'd257, 64'h0,                   0,   2'd1, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FF80, 9'd2,   64'hFFFF_FFFF_FFFF_FF00, 2,   2'd0, 1'b1};
    vecs[4] = '{64'h0000_0040_0000_00FF, 9'd1,   64'h0000_0040_0000_0000, 1,   2'd0, 1'b1};
    vecs[5] = '{64'h0000_0000_8000_0000, 9'd256, 64'h0000_0000_8000_0000, 256, 2'd0, 1'b1};

    #2;
    chk("rst_ready", {63'b0, req_ready_o}, 64'd1);
    chk("rst_outs_zero", {63'b0, |non_ready_outs}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    rd_valid_i = 1'b1;
    foreach (vecs[i]) begin
      load_seq(vecs[i].base, vecs[i].pages, vecs[i].exp_create);
      chk("vec_creates", 64'(n_create), vecs[i].exp_adds > 0 ? 64'd1 : 64'd0);
      chk("vec_adds", 64'(n_add), 64'(vecs[i].exp_adds));
      chk("vec_init", 64'(n_init), {63'b0, vecs[i].exp_run});
      chk("vec_enter", 64'(n_enter), {63'b0, vecs[i].exp_run});
      chk("vec_code", {62'b0, err_code_o}, {62'b0, vecs[i].exp_code});
      chk("vec_running", {63'b0, running_o}, {63'b0, vecs[i].exp_run});
      chk("vec_err", {63'b0, err_o}, {63'b0, !vecs[i].exp_run});
      if (running_o) exit_seq(1);
    end

    // Fetch never answered: 64 request cycles, then timeout error.
    rd_valid_i = 1'b0;
    n_rd = 0; n_add = 0;
    req_base_i = 64'h0000_0000_0001_0000; req_pages_i = 9'd2; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 200 && !err_o; c++) begin
      if (rd_req_o) n_rd++;
      if (eadd_o) n_add++;
      tick();
    end
    chk("tmo_fetch_cycles", 64'(n_rd), 64'd64);
    chk("tmo_code", {62'b0, err_code_o}, 64'd2);
    chk("tmo_rd_req_low", {63'b0, rd_req_o}, 64'd0);
    chk("tmo_no_eadd", 64'(n_add), 64'd0);
    rd_valid_i = 1'b1;

    // Fault and exit together in RUN: fault wins.
    load_seq(64'h0000_0000_0002_0000, 9'd1, 64'h0000_0000_0002_0000);
    chk("fault_pre_run", {63'b0, running_o}, 64'd1);
    n_exit = 0; n_done = 0;
    for (int c = 0; c < 10; c++) begin
      sgx_fault_i = (c == 0);
      exit_req_i  = (c == 0);
      tick();
      if (eexit_o) n_exit++;
      if (done_o) n_done++;
    end
    chk("fault_eexit", 64'(n_exit), 64'd1);
    chk("fault_no_done", 64'(n_done), 64'd0);
    chk("fault_code", {62'b0, err_code_o}, 64'd3);
    chk("fault_err", {63'b0, err_o}, 64'd1);

    // Clean exit, active_i drops three cycles after the request.
    load_seq(64'h0000_0000_0003_0000, 9'd1, 64'h0000_0000_0003_0000);
    chk("exit_pre_run", {63'b0, running_o}, 64'd1);
    chk("exit_pre_code", {62'b0, err_code_o}, 64'd0);
    exit_seq(3);
    chk("exit_eexit", 64'(n_exit), 64'd1);
    chk("exit_done", 64'(n_done), 64'd1);
    chk("exit_ready", {63'b0, req_ready_o}, 64'd1);
    chk("exit_idle", {63'b0, busy_o | err_o}, 64'd0);

    // Reset asserted during the second fetch, then a fresh load.
    req_base_i = 64'h0000_ABCD_0000_1000; req_pages_i = 9'd3; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 20 && !eadd_o; c++) tick();
    rd_valid_i = 1'b0;
    tick();
    chk("rst2_in_fetch", {63'b0, rd_req_o}, 64'd1);
    chk("rst2_fetch_addr", rd_addr_o, 64'h0000_ABCD_0000_1100);
    rst_n = 1'b0;
    #1;
    chk("rst2_outs_zero", {63'b0, |non_ready_outs}, 64'd0);
    chk("rst2_ready", {63'b0, req_ready_o}, 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    rd_valid_i = 1'b1;
    load_seq(64'h0000_0000_0004_0010, 9'd2, 64'h0000_0000_0004_0000);
    chk("rst2_recreate", 64'(n_create), 64'd1);
    chk("rst2_adds", 64'(n_add), 64'd2);
    chk("rst2_running", {63'b0, running_o}, 64'd1);
    exit_seq(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sgx_enclave_loader.md
SGX_ENCLAVE_LOADER -- requirements
Module: sgx_enclave_loader

Interface
REQ-001 SHALL have parameter MAX_PAGES, default 256, meaning the maximum pages per enclave load.
REQ-002 SHALL have parameter RD_TIMEOUT, default 64, meaning the cycles allowed per page fetch and per active_i wait.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have request ports:
- req_valid_i  in  1  load request.
- req_ready_o  out  1  request accepted when both high.
- req_base_i  in  64  enclave base address.
- req_pages_i  in  9  page count.
- exit_req_i  in  1  software exit request.
REQ-005 SHALL have page-fetch ports:
- rd_req_o  out  1  fetch request.
- rd_addr_o  out  64  fetch address.
- rd_valid_i  in  1  fetch data valid.
- rd_data_i  in  64  fetch data.
REQ-006 SHALL have enclave-controller command ports, all outputs:
- ecreate_o, eadd_o, einit_o, eenter_o, eexit_o  1 each  single-cycle command pulses.
- addr_o  64  command address.
- wdata_o  64  EADD data.
REQ-007 SHALL have status ports:
- active_i  in  1  controller enclave-active level.
- sgx_fault_i  in  1  controller fault level.
- busy_o  out  1  not IDLE and not ERROR.
- running_o  out  1  state is RUN.
- done_o  out  1  one-cycle pulse on clean exit.
- err_o  out  1  ERROR state.
- err_code_o  out  2  0 none, 1 bad length, 2 timeout, 3 fault.

Function
REQ-008 SHALL implement FSM states IDLE, CREATE, FETCH, ADD, INIT, ENTER, WAIT_ACT, RUN, EXIT, ERROR.
REQ-009 SHALL assert req_ready_o only in IDLE and ERROR; acceptance clears err_o and err_code_o.
REQ-010 SHALL, on acceptance with req_pages_i of 0 or greater than MAX_PAGES, go to ERROR with code 1 and issue no commands.
REQ-011 SHALL register base = {req_base_i[63:8], 8'h00} on acceptance; page k address = base + k*256, 64-bit wrapping add.
REQ-012 SHALL, in CREATE, pulse ecreate_o for one cycle with addr_o = base, then go to FETCH with k = 0.
REQ-013 SHALL, in FETCH, hold rd_req_o high with rd_addr_o = page k address until rd_valid_i is sampled high in the same cycle; it SHALL then capture rd_data_i and go to ADD.
REQ-014 SHALL, in ADD, pulse eadd_o for one cycle with addr_o = page k address and wdata_o = the captured data; it SHALL increment k and return to FETCH, or go to INIT after the last page.
REQ-015 SHALL pulse einit_o for one cycle in INIT, then pulse eenter_o for one cycle in ENTER, then go to WAIT_ACT.
REQ-016 SHALL leave WAIT_ACT for RUN when active_i is high.
REQ-017 SHALL, in RUN, treat sgx_fault_i as a fault; when sgx_fault_i and exit_req_i are both high, the fault SHALL take priority.
REQ-018 SHALL, on a fault, pulse eexit_o and go to ERROR with code 3.
REQ-019 SHALL, on exit_req_i alone, pulse eexit_o and go to EXIT.
REQ-020 SHALL, in EXIT, wait for active_i low, then pulse done_o and go to IDLE; if active_i is still high after RD_TIMEOUT cycles it SHALL go to ERROR with code 2.
REQ-021 SHALL run a timeout counter that clears on each FETCH or WAIT_ACT entry; reaching RD_TIMEOUT cycles SHALL cause ERROR with code 2 and deassert rd_req_o.
REQ-022 SHALL ignore exit_req_i outside RUN, and rd_valid_i outside FETCH.
REQ-023 SHALL drive addr_o and wdata_o to zero whenever no command pulse is active.
REQ-024 SHALL never assert more than one command pulse in the same cycle.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-load, enter IDLE with k, the counter, and every output zero, except req_ready_o which is 1.

Structure
REQ-026 SHALL take the state enum, the error-code enum, PAGE_SHIFT=8 and the MAX_PAGES default from shared package sgx_pkg.
REQ-027 SHALL instantiate one sub-module, sgx_timeout_ctr, a clearable saturating counter with RD_TIMEOUT compare.

Verification
REQ-028 SHALL cover: base 0x1234_5678, pages 2, rd_valid_i same-cycle -> ecreate_o with addr_o 0x1234_5600; eadd_o at 0x1234_5600 and 0x1234_5700 with the fetched data; einit_o; eenter_o; active_i high -> running_o high.
REQ-029 SHALL cover: pages 0, and separately pages 257 -> err_o high with err_code_o 1 and no command pulses.
REQ-030 SHALL cover: rd_valid_i never asserted -> after 64 FETCH cycles err_code_o 2, rd_req_o low, no eadd_o.
REQ-031 SHALL cover: in RUN, sgx_fault_i and exit_req_i high together -> one eexit_o pulse and err_code_o 3, no done_o.
REQ-032 SHALL cover: in RUN, exit_req_i, then active_i low 3 cycles later -> eexit_o once, then done_o one cycle, then IDLE with req_ready_o 1.
REQ-033 SHALL cover: rst_n asserted low during the second FETCH -> all outputs 0 immediately; a new request afterwards restarts at ecreate_o.
